warmboot_seq: RTL and testbench

Sequencer between the bootloader's `boot` request and the iCE40 `SB_WARMBOOT` primitive. It latches the requested image index and waits until the SPI flash and USB transmitter have both been quiet for a programmable interval. It then drives stable S1/S0 selects and issues a glitch-free, minimum-width BOOT pulse. This keeps reconfiguration from cutting off an in-flight USB ACK or flash access.

---
 rtl/warmboot_seq.sv | 133 +++++++++++++
 tb/tb_warmboot_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/warmboot_seq.sv
// Sequences a bootloader boot request into SB_WARMBOOT: waits for a quiet SPI/USB bus,
// then settles S1/S0 before a fixed-width BOOT pulse. Terminal until reset.
module warmboot_seq #(
    parameter int          DELAY_CYCLES  = 48000,
    parameter int          PULSE_CYCLES  = 16,
    parameter logic [1:0]  IMAGE_DEFAULT = 2'b01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       boot_req,
    input  logic [1:0] image_sel,
    input  logic       spi_cs,
    input  logic       usb_tx_en,
    output logic       wb_s1,
    output logic       wb_s0,
    output logic       wb_boot,
    output logic       busy
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] QUIET = 3'd1;
    localparam logic [2:0] SETUP = 3'd2;
    localparam logic [2:0] PULSE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int QCNT_W = $clog2(DELAY_CYCLES + 1);
    localparam int PH_MAX = (PULSE_CYCLES > 2) ? PULSE_CYCLES : 2;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [QCNT_W-1:0] QCNT_LAST      = QCNT_W'(DELAY_CYCLES - 1);
    localparam logic [PH_W-1:0]   PH_SETUP_LAST  = PH_W'(1);
    localparam logic [PH_W-1:0]   PH_PULSE_LAST  = PH_W'(PULSE_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [QCNT_W-1:0] qcnt_q, qcnt_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [1:0]        img_q, img_d;
    logic              req_q;
    logic              wb_boot_q, wb_boot_d;
    logic [1:0]        sel_q, sel_d;
    logic              busy_q, busy_d;

    logic req_rise;
    logic quiet;

    assign req_rise = boot_req & ~req_q;
    assign quiet    = spi_cs & ~usb_tx_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            qcnt_q    <= '0;
            ph_q      <= '0;
            img_q     <= IMAGE_DEFAULT;
            req_q     <= 1'b0;
            wb_boot_q <= 1'b0;
            sel_q     <= IMAGE_DEFAULT;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            ph_q      <= ph_d;
            img_q     <= img_d;
            req_q     <= boot_req;
            wb_boot_q <= wb_boot_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        ph_d    = ph_q;
        img_d   = img_q;
        case (state_q)
            IDLE: begin
                if (req_rise) begin
                    img_d   = image_sel;
                    qcnt_d  = '0;
                    state_d = QUIET;
                end
            end
            QUIET: begin
                // Any bus activity restarts the whole quiet interval.
                if (!quiet) begin
                    qcnt_d = '0;
                end else if (qcnt_q == QCNT_LAST) begin
                    qcnt_d  = '0;
                    ph_d    = '0;
                    state_d = SETUP;
                end else if (qcnt_q != {QCNT_W{1'b1}}) begin
                    qcnt_d = qcnt_q + 1'b1;
                end
            end
            SETUP: begin
                if (ph_q == PH_SETUP_LAST) begin
                    ph_d    = '0;
                    state_d = PULSE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            PULSE: begin
                if (ph_q == PH_PULSE_LAST) begin
                    ph_d    = '0;
                    state_d = DONE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs lag the state by one register so selects lead BOOT by the full SETUP time.
    always_comb begin
        wb_boot_d = (state_q == PULSE);
        sel_d     = (state_q == SETUP) ? img_q : sel_q;
        busy_d    = (state_d != IDLE);
    end

    assign wb_boot = wb_boot_q;
    assign wb_s1   = sel_q[1];
    assign wb_s0   = sel_q[0];
    assign busy    = busy_q;

endmodule

// File: tb/tb_warmboot_seq.sv
// Scoreboard bench for warmboot_seq (DELAY_CYCLES=8, PULSE_CYCLES=4): stimulus pushes
// expected BOOT pulses, a negedge monitor checks rise cycle, selects and width.
module tb_warmboot_seq;

    localparam int D = 8;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       boot_req = 1'b0;
    logic [1:0] image_sel = 2'b00;
    logic       spi_cs = 1'b1;
    logic       usb_tx_en = 1'b0;
    logic       wb_s1, wb_s0, wb_boot, busy;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int         rise;
        logic [1:0] sel;
        int         width;
    } exp_t;

    exp_t exp_q[$];

    warmboot_seq #(
        .DELAY_CYCLES (D),
        .PULSE_CYCLES (P),
        .IMAGE_DEFAULT(2'b01)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .boot_req (boot_req),
        .image_sel(image_sel),
        .spi_cs   (spi_cs),
        .usb_tx_en(usb_tx_en),
        .wb_s1    (wb_s1),
        .wb_s0    (wb_s0),
        .wb_boot  (wb_boot),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int r, input logic [1:0] s, input int w);
        exp_t e;
        e.rise  = r;
        e.sel   = s;
        e.width = w;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    exp_t cur;
    logic in_pulse = 1'b0;
    logic have_cur = 1'b0;
    int   width = 0;

    always @(negedge clk) begin
        if (wb_boot && !in_pulse) begin
            in_pulse = 1'b1;
            width    = 1;
            if (exp_q.size() == 0) begin
                have_cur = 1'b0;
                check("unexpected_pulse", 1, 0);
            end else begin
                cur      = exp_q.pop_front();
                have_cur = 1'b1;
                check("rise_cycle", cyc, cur.rise);
                check("sel_at_rise", int'({wb_s1, wb_s0}), int'(cur.sel));
            end
        end else if (wb_boot && in_pulse) begin
            width++;
        end else if (!wb_boot && in_pulse) begin
            in_pulse = 1'b0;
            if (have_cur) check("pulse_width", width, cur.width);
        end
    end

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        boot_req  = 1'b0;
        spi_cs    = 1'b1;
        usb_tx_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic request(input logic [1:0] sel, output int e0);
        @(negedge clk);
        image_sel = sel;
        boot_req  = 1'b1;
        e0        = cyc + 1;
    endtask

    initial begin
        int e0;
        int c;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_wb_boot", int'(wb_boot), 0);
        check("rst_sel", int'({wb_s1, wb_s0}), 1);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;

        // Clean boot
        request(2'b10, e0);
        push(e0 + D + 3, 2'b10, P);
        goto(e0);
        check("clean_busy_after_e0", int'(busy), 1);
        image_sel = 2'b00;
        goto(e0 + D);
        check("clean_sel_before_setup", int'({wb_s1, wb_s0}), 1);
        goto(e0 + D + 1);
        check("clean_sel_setup", int'({wb_s1, wb_s0}), 2);
        check("clean_boot_low_in_setup", int'(wb_boot), 0);
        goto(e0 + 22);
        check("clean_done_busy", int'(busy), 1);
        check("clean_done_boot", int'(wb_boot), 0);
        check("clean_done_sel", int'({wb_s1, wb_s0}), 2);

        // Activity restart: spi_cs sampled low at edge E0+6
        do_reset();
        check("after_reset_busy", int'(busy), 0);
        request(2'b10, e0);
        push(e0 + D + 3 + 6, 2'b10, P);
        goto(e0 + 5);
        spi_cs = 1'b0;
        goto(e0 + 6);
        spi_cs = 1'b1;
        goto(e0 + 28);
        check("restart_busy", int'(busy), 1);

        // Ignored second request
        do_reset();
        request(2'b10, e0);
        push(e0 + D + 3, 2'b10, P);
        goto(e0 + 2);
        boot_req  = 1'b0;
        image_sel = 2'b11;
        goto(e0 + 3);
        boot_req = 1'b1;
        goto(e0 + 30);
        boot_req = 1'b0;
        check("ignored_sel", int'({wb_s1, wb_s0}), 2);

        // Reset in the middle of the pulse
        do_reset();
        request(2'b11, e0);
        push(e0 + D + 3, 2'b11, 2);
        goto(e0 + D + 4);
        #2;
        reset    = 1'b1;
        boot_req = 1'b0;
        #1;
        check("midrst_boot_async", int'(wb_boot), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_sel", int'({wb_s1, wb_s0}), 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        goto(cyc + 25);
        check("midrst_idle_busy", int'(busy), 0);
        request(2'b00, e0);
        push(e0 + D + 3, 2'b00, P);
        goto(e0 + 22);

        // Continuous USB activity
        do_reset();
        usb_tx_en = 1'b1;
        request(2'b10, e0);
        goto(e0 + 30);
        check("usb_hold_busy", int'(busy), 1);
        check("usb_hold_boot", int'(wb_boot), 0);
        c = cyc;
        usb_tx_en = 1'b0;
        push(c + D + 3, 2'b10, P);
        goto(c + 25);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
